// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory controller.
// Array hits return the word in the same cycle; a miss fetches the word and bypasses it to fetch.
module icache_dm #(
  parameter  int SETS  = 16,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        miss_addr_reg;
  logic [31:0]        hit_count_reg, miss_count_reg;
  logic [SETS-1:0]    valid_reg;
  logic [TAG_W-1:0]   tag_mem  [SETS];
  logic [31:0]        data_mem [SETS];

  logic [IDX_W-1:0]   req_idx, miss_idx;
  logic [TAG_W-1:0]   req_tag, miss_tag;
  logic               array_hit, miss_start, fill_done;
  logic               unused_addr_lsb;

  assign req_idx   = imemaddr[IDX_W+1:2];
  assign req_tag   = imemaddr[31:IDX_W+2];
  assign miss_idx  = miss_addr_reg[IDX_W+1:2];
  assign miss_tag  = miss_addr_reg[31:IDX_W+2];
  assign unused_addr_lsb = ^imemaddr[1:0];

  assign array_hit  = imemREN & valid_reg[req_idx] & (tag_mem[req_idx] == req_tag);
  assign miss_start = (state_reg == IDLE) & imemREN & ~array_hit;
  assign fill_done  = (state_reg == FILL) & ~iwait;

  // State register
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: once issued, a fill always runs to completion
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (miss_start) state_next = FILL;
      FILL:    if (!iwait)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; the fill cycle forwards iload only if fetch still wants that word
  always_comb begin
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    case (state_reg)
      IDLE: begin
        if (array_hit) begin
          ihit     = 1'b1;
          imemload = data_mem[req_idx];
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr_reg;
        if (!iwait && imemREN && (imemaddr[31:2] == miss_addr_reg[31:2])) begin
          ihit     = 1'b1;
          imemload = iload;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      miss_addr_reg  <= 32'h0;
      hit_count_reg  <= 32'h0;
      miss_count_reg <= 32'h0;
      valid_reg      <= '0;
    end else begin
      if (miss_start) begin
        miss_addr_reg <= {imemaddr[31:2], 2'b00};
        if (miss_count_reg != 32'hFFFF_FFFF) miss_count_reg <= miss_count_reg + 32'd1;
      end
      if ((state_reg == IDLE) && array_hit && (hit_count_reg != 32'hFFFF_FFFF))
        hit_count_reg <= hit_count_reg + 32'd1;
      if (fill_done)
        valid_reg[miss_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset: the valid bits qualify every entry
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= iload;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
endmodule
